// File: rtl/calc_seq_unit.sv
// Multi-cycle unsigned calculator: one-cycle add/sub, shift-add multiply and restoring divide.
// The divider is built only when the CALC_DIVIDER_EN macro is defined.
module calc_seq_unit #(
  parameter int WIDTH = 8
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  input  logic [1:0]           fct_i,
  output logic                 busy_o,
  output logic [2*WIDTH-1:0]   res_o,
  output logic [2*WIDTH-1:0]   rem_o,
  output logic                 done_o,
  output logic                 err_o
);

  localparam int DW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, ARITH, MUL, DIV} state_t;
  typedef enum logic [1:0] {FCT_ADD = 2'b00, FCT_SUB = 2'b01, FCT_MUL = 2'b10, FCT_DIV = 2'b11} fct_t;

  state_t            state_q, state_d;
  fct_t              fct_q, fct_d;
  logic [DW-1:0]     opa_q, opa_d;
  logic [WIDTH-1:0]  opb_q, opb_d;
  logic [DW-1:0]     acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DW-1:0]     res_q, res_d;
  logic [DW-1:0]     rem_q, rem_d;
  logic              err_q, err_d;
  logic              done_q, done_d;

  // One multiply step: add the shifted multiplicand when the current bit of b is set.
  logic [DW-1:0]     prod_step;
  assign prod_step = acc_q + (opb_q[0] ? opa_q : DW'(0));

`ifdef CALC_DIVIDER_EN
  // Restoring step: bring down the next dividend bit, subtract the divisor and keep
  // the difference only when it did not borrow.
  logic [WIDTH:0]    div_part, div_diff;
  logic              div_ge;
  logic [WIDTH-1:0]  rem_step, quo_step;
  assign div_part = {acc_q[WIDTH-1:0], opa_q[WIDTH-1]};
  assign div_diff = div_part - {1'b0, opb_q};
  assign div_ge   = ~div_diff[WIDTH];
  assign rem_step = div_ge ? div_diff[WIDTH-1:0] : div_part[WIDTH-1:0];
  assign quo_step = {opa_q[WIDTH-2:0], div_ge};
`endif

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_d = state_q;
    fct_d   = fct_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    rem_d   = rem_q;
    err_d   = err_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          opa_d = {{WIDTH{1'b0}}, a_i};
          opb_d = b_i;
          fct_d = fct_t'(fct_i);
          acc_d = '0;
          cnt_d = '0;
          case (fct_t'(fct_i))
            FCT_MUL: state_d = MUL;
`ifdef CALC_DIVIDER_EN
            FCT_DIV: state_d = DIV;
`endif
            default: state_d = ARITH;
          endcase
        end
      end

      ARITH: begin
        state_d = IDLE;
        done_d  = 1'b1;
        rem_d   = '0;
        err_d   = 1'b0;
        case (fct_q)
          FCT_ADD: res_d = opa_q + {{WIDTH{1'b0}}, opb_q};
          FCT_SUB: res_d = opa_q - {{WIDTH{1'b0}}, opb_q};
          // Only a divide request lands here, and only when no divider is built.
          default: begin
            res_d = '0;
            err_d = 1'b1;
          end
        endcase
      end

      MUL: begin
        acc_d = prod_step;
        opa_d = opa_q << 1;
        opb_d = opb_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
          res_d   = prod_step;
          rem_d   = '0;
          err_d   = 1'b0;
          cnt_d   = '0;
        end
      end

`ifdef CALC_DIVIDER_EN
      DIV: begin
        if (opb_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
          res_d   = '1;
          rem_d   = opa_q;
          err_d   = 1'b1;
        end else begin
          acc_d = {{WIDTH{1'b0}}, rem_step};
          opa_d = {opa_q[DW-1:WIDTH], quo_step};
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
            res_d   = {{WIDTH{1'b0}}, quo_step};
            rem_d   = {{WIDTH{1'b0}}, rem_step};
            err_d   = 1'b0;
            cnt_d   = '0;
          end
        end
      end
`endif

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      fct_q   <= FCT_ADD;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q <= state_d;
      fct_q   <= fct_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign busy_o = (state_q != IDLE);
  assign res_o  = res_q;
  assign rem_o  = rem_q;
  assign err_o  = err_q;
  assign done_o = done_q;

  // Completion always returns to IDLE, so a done pulse never overlaps busy.
  done_not_busy: assert property (@(posedge clock_i) disable iff (!reset_i) done_o |-> !busy_o);

endmodule

// File: tb/tb_calc_seq_unit.sv
// Self-checking bench for calc_seq_unit: vector table through a scoreboard queue, plus
// hand-written sequences for ignored start, back-to-back issue and reset abort.
module tb_calc_seq_unit;

  localparam int W  = 8;
  localparam int DW = 2 * W;

  logic          clock_i = 1'b0;
  logic          reset_i = 1'b0;
  logic          start_i = 1'b0;
  logic [W-1:0]  a_i     = '0;
  logic [W-1:0]  b_i     = '0;
  logic [1:0]    fct_i   = '0;
  logic          busy_o;
  logic [DW-1:0] res_o;
  logic [DW-1:0] rem_o;
  logic          done_o;
  logic          err_o;

  calc_seq_unit #(.WIDTH(W)) dut (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .start_i (start_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .fct_i   (fct_i),
    .busy_o  (busy_o),
    .res_o   (res_o),
    .rem_o   (rem_o),
    .done_o  (done_o),
    .err_o   (err_o)
  );

  always #5 clock_i = ~clock_i;

  typedef struct {
    string         name;
    logic [1:0]    fct;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [DW-1:0] res;
    logic [DW-1:0] rem;
    logic          err;
    int            lat;
  } vec_t;

  typedef struct {
    string         name;
    logic [DW-1:0] res;
    logic [DW-1:0] rem;
    logic          err;
    int            lat;
    int            acc_cyc;
  } exp_t;

  exp_t          sb[$];
  vec_t          tbl[$];
  int            cyc      = 0;
  int            n_checks = 0;
  int            n_pass   = 0;
  int            n_done   = 0;
  logic [DW-1:0] model_res = '0;

  always @(posedge clock_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Scoreboard: every done pulse pops the oldest outstanding request.
  always @(negedge clock_i) begin : monitor
    exp_t e;
    if (reset_i && done_o === 1'b1) begin
      n_done++;
      if (sb.size() == 0) begin
        check("done_without_request", 64'(sb.size()), 64'(1));
      end else begin
        e = sb.pop_front();
        check({e.name, "_res"}, 64'(res_o), 64'(e.res));
        check({e.name, "_rem"}, 64'(rem_o), 64'(e.rem));
        check({e.name, "_err"}, 64'(err_o), 64'(e.err));
        check({e.name, "_lat"}, 64'(cyc - e.acc_cyc), 64'(e.lat));
        model_res = e.res;
      end
    end
  end

  // Raise start and hold it until the DUT can accept; outputs must hold at acceptance.
  task automatic issue(input string name, input logic [1:0] f, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [DW-1:0] r, input logic [DW-1:0] m,
                       input logic e, input int lat);
    int guard;
    @(negedge clock_i);
    fct_i   = f;
    a_i     = a;
    b_i     = b;
    start_i = 1'b1;
    guard   = 0;
    while (busy_o && guard < 64) begin
      @(negedge clock_i);
      guard++;
    end
    check({name, "_accept_wait"}, 64'(busy_o), 64'(0));
    sb.push_back('{name, r, m, e, lat, cyc + 1});
    @(negedge clock_i);
    start_i = 1'b0;
    a_i     = W'($urandom);
    b_i     = W'($urandom);
    fct_i   = 2'($urandom);
    check({name, "_busy"}, 64'(busy_o), 64'(1));
    check({name, "_hold"}, 64'(res_o), 64'(model_res));
  endtask

  task automatic wait_drain(input string name);
    int guard = 0;
    while (sb.size() != 0 && guard < 100) begin
      @(negedge clock_i);
      guard++;
    end
    check({name, "_drained"}, 64'(sb.size()), 64'(0));
  endtask

  task automatic check_zero_outputs(input string name);
    check({name, "_busy"}, 64'(busy_o), 64'(0));
    check({name, "_done"}, 64'(done_o), 64'(0));
    check({name, "_err"},  64'(err_o),  64'(0));
    check({name, "_res"},  64'(res_o),  64'(0));
    check({name, "_rem"},  64'(rem_o),  64'(0));
  endtask

  initial begin
    int d0;
    tbl.push_back('{"add_3_7",    2'b00, 8'h03, 8'h07, 16'h000A, 16'h0000, 1'b0, 1});
    tbl.push_back('{"sub_3_7",    2'b01, 8'h03, 8'h07, 16'hFFFC, 16'h0000, 1'b0, 1});
    tbl.push_back('{"mul_ff_ff",  2'b10, 8'hFF, 8'hFF, 16'hFE01, 16'h0000, 1'b0, W});
    tbl.push_back('{"mul_3_7",    2'b10, 8'h03, 8'h07, 16'h0015, 16'h0000, 1'b0, W});
    tbl.push_back('{"add_ff_ff",  2'b00, 8'hFF, 8'hFF, 16'h01FE, 16'h0000, 1'b0, 1});
    tbl.push_back('{"sub_7_3",    2'b01, 8'h07, 8'h03, 16'h0004, 16'h0000, 1'b0, 1});
    tbl.push_back('{"mul_80_2",   2'b10, 8'h80, 8'h02, 16'h0100, 16'h0000, 1'b0, W});
    tbl.push_back('{"mul_0_5",    2'b10, 8'h00, 8'h05, 16'h0000, 16'h0000, 1'b0, W});
`ifdef CALC_DIVIDER_EN
    tbl.push_back('{"div_200_7",  2'b11, 8'd200, 8'd7,  16'h001C, 16'h0004, 1'b0, W});
    tbl.push_back('{"div_5_0",    2'b11, 8'd5,   8'd0,  16'hFFFF, 16'h0005, 1'b1, 1});
    tbl.push_back('{"div_255_1",  2'b11, 8'd255, 8'd1,  16'h00FF, 16'h0000, 1'b0, W});
    tbl.push_back('{"div_7_200",  2'b11, 8'd7,   8'd200, 16'h0000, 16'h0007, 1'b0, W});
`else
    tbl.push_back('{"div_200_7",  2'b11, 8'd200, 8'd7,  16'h0000, 16'h0000, 1'b1, 1});
    tbl.push_back('{"div_5_0",    2'b11, 8'd5,   8'd0,  16'h0000, 16'h0000, 1'b1, 1});
`endif
    tbl.push_back('{"add_after_err", 2'b00, 8'h10, 8'h20, 16'h0030, 16'h0000, 1'b0, 1});

    repeat (3) @(negedge clock_i);
    check_zero_outputs("in_reset");
    reset_i = 1'b1;
    repeat (10) @(negedge clock_i);
    check("idle_done_count", 64'(n_done), 64'(0));
    check_zero_outputs("idle");

    foreach (tbl[i]) begin
      issue(tbl[i].name, tbl[i].fct, tbl[i].a, tbl[i].b,
            tbl[i].res, tbl[i].rem, tbl[i].err, tbl[i].lat);
      wait_drain(tbl[i].name);
    end

    // Start pulse while busy is ignored; start held through the done cycle is taken at once.
    d0 = n_done;
    issue("busy_mul_3_7", 2'b10, 8'h03, 8'h07, 16'h0015, 16'h0000, 1'b0, W);
    repeat (2) @(negedge clock_i);
    fct_i   = 2'b00;
    a_i     = 8'h05;
    b_i     = 8'h05;
    start_i = 1'b1;
    @(negedge clock_i);
    start_i = 1'b0;
    issue("b2b_add_1_1", 2'b00, 8'h01, 8'h01, 16'h0002, 16'h0000, 1'b0, 1);
    wait_drain("b2b");
    check("b2b_done_count", 64'(n_done - d0), 64'(2));

    // Reset in the middle of a long operation aborts it with no late done.
`ifdef CALC_DIVIDER_EN
    issue("abort_div", 2'b11, 8'd200, 8'd7, 16'h001C, 16'h0004, 1'b0, W);
`else
    issue("abort_mul", 2'b10, 8'd200, 8'd7, 16'h0578, 16'h0000, 1'b0, W);
`endif
    repeat (3) @(negedge clock_i);
    reset_i = 1'b0;
    sb.delete();
    model_res = '0;
    #1;
    check_zero_outputs("abort_reset");
    repeat (2) @(negedge clock_i);
    reset_i = 1'b1;
    d0 = n_done;
    repeat (12) @(negedge clock_i);
    check("abort_no_done", 64'(n_done - d0), 64'(0));
    issue("post_reset_add_2_2", 2'b00, 8'h02, 8'h02, 16'h0004, 16'h0000, 1'b0, 1);
    wait_drain("post_reset");

    repeat (3) @(negedge clock_i);
    check("final_queue_empty", 64'(sb.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/calc_seq_unit.md
Name: calc_seq_unit

Overview:
- Parametrised multi-cycle integer calculator: add, subtract, shift-add multiply and restoring divide.
- Handshake: start/busy/done.
- Next-generation calculator core for the calculator top level and its test wrapper. Replaces fixed-operand, single-mode operation with full per-request function select, divide-by-zero error reporting and back-to-back issue.

Parameters:
WIDTH, 8, operand width in bits; must be >= 2; results are 2*WIDTH bits

Ports:
clock_i  input  1  system clock, rising-edge
reset_i  input  1  asynchronous, active-low reset
start_i  input  1  request; accepted on a rising edge when busy_o=0
a_i  input  WIDTH  operand A (dividend), unsigned
b_i  input  WIDTH  operand B (divisor), unsigned
fct_i  input  2  function: 00 add, 01 sub, 10 mul, 11 div
busy_o  output  1  high while an operation is in flight
res_o  output  2*WIDTH  result (sum, difference, product, quotient)
rem_o  output  2*WIDTH  remainder (div only, else 0)
done_o  output  1  one-cycle completion pulse
err_o  output  1  divide-by-zero flag, valid with done_o

Behaviour:
- Reset (reset_i=0, asynchronous): state IDLE; busy_o=0, done_o=0, err_o=0, res_o=0, rem_o=0; internal operand, accumulator and counter registers cleared.
- Reset mid-operation aborts the operation. No done_o is produced after reset release.
- States: IDLE, ARITH, MUL, DIV.
- IDLE + start_i=1 at edge E0:
  - Capture a_i, b_i, fct_i into registers.
  - Next state: ARITH for fct 00/01, MUL for 10, DIV for 11.
  - busy_o=1 from E0.
- start_i while busy_o=1 is ignored: no capture, in-flight operation unaffected.
- ARITH, one cycle:
  - At E1, res_o is loaded and rem_o=0.
  - add: zero-extended a+b.
  - sub: zero-extended a minus zero-extended b, modulo 2^(2*WIDTH), i.e. two's complement when a<b.
- MUL:
  - WIDTH iterations of shift-add on a 2*WIDTH accumulator, one bit of b per cycle, LSB first.
  - Iteration counter runs 0..WIDTH-1.
  - Result loads at edge E(WIDTH). rem_o=0.
- DIV:
  - Restoring division, one quotient bit per cycle, MSB first, WIDTH cycles.
  - Quotient and remainder load at E(WIDTH). Both are zero-extended to 2*WIDTH.
- DIV with b=0:
  - Detected at E1; no iterations run.
  - res_o = all ones; rem_o = zero-extended a; err_o=1.
- Completion edge:
  - res_o, rem_o and err_o update.
  - done_o=1 for exactly the following cycle; busy_o=0 and state=IDLE at the same edge.
  - err_o is 0 for every non-error completion.
- Result hold: res_o, rem_o and err_o hold until the next completion. They do not change at acceptance.
- Back-to-back: start_i=1 during the done_o cycle is accepted at that edge. Zero idle cycles are required between operations.
- Latency from acceptance edge to done_o rising: 1 cycle for add/sub/div-by-zero; WIDTH cycles for mul/div.
- Inputs a_i, b_i, fct_i are don't-care except at the acceptance edge.

Optional Feature:
- Macro: CALC_DIVIDER_EN.
- Defined: DIV state and restoring divider are built as above.
- Undefined:
  - No divider logic is built.
  - fct_i=11 completes after 1 cycle (as ARITH) with res_o=0, rem_o=0, err_o=1.
  - Add, sub and mul are unchanged.

Test Plan:
- WIDTH=8; reset_i low for 3 cycles, then release -> all outputs 0, busy_o=0; no done_o for 10 idle cycles.
- Add a=8'h03, b=8'h07 -> done_o 1 cycle after acceptance, res_o=16'h000A, rem_o=0, err_o=0. Then sub 3-7 -> res_o=16'hFFFC.
- Mul a=8'hFF, b=8'hFF -> done_o 8 cycles after acceptance, res_o=16'hFE01. Mul 3x7 -> 16'h0015.
- Div a=200, b=7 -> res_o=28, rem_o=4 after 8 cycles. Div a=5, b=0 -> after 1 cycle res_o=16'hFFFF, rem_o=5, err_o=1. Without CALC_DIVIDER_EN -> res_o=0, rem_o=0, err_o=1 after 1 cycle.
- Start mul 3x7, pulse start_i with add operands at cycle 3 -> extra request ignored; single done_o with 16'h0015. Then start_i held high through the done_o cycle with add 1+1 -> accepted immediately; next done_o gives 16'h0002.
- Start div 200/7, assert reset_i low at cycle 4 -> outputs 0 immediately; no done_o after release; a new add 2+2 completes with res_o=4.
